// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel pixel feeder: frame defaults, core state codes, feeder FSM.
// Latency: n/a (package). Backpressure: n/a.
package sobel_pkg;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;

    localparam logic [1:0] SOBEL_ST_IDLE   = 2'd0;
    localparam logic [1:0] SOBEL_ST_LOAD   = 2'd1;
    localparam logic [1:0] SOBEL_ST_RUN    = 2'd2;
    localparam logic [1:0] SOBEL_ST_FINISH = 2'd3;

    typedef enum logic [2:0] {
        FD_IDLE,
        FD_PRIME,
        FD_ARM,
        FD_STREAM,
        FD_DRAIN,
        FD_DONE
    } fdState_t;

    // Core pulls a pixel whenever it is loading or running and not padding.
    function automatic logic coreFetching(input logic [1:0] sobelState, input logic sobelPad);
        return ((sobelState == SOBEL_ST_LOAD) || (sobelState == SOBEL_ST_RUN)) && !sobelPad;
    endfunction

endpackage

// File: rtl/feeder_addr_ctr.sv
// Pixel index counter with look-ahead RAM address so read data lines up with the current index.
// Latency: memAddr combinational; idx advances on the edge after inc. Backpressure: inc=0 freezes idx.
module feeder_addr_ctr #(
    parameter int ADDR_W  = 16,
    parameter int PIX_CNT = 65536
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] idx,
    output logic [ADDR_W-1:0] memAddr,
    output logic              isLast
);

    assign isLast = (idx == ADDR_W'(PIX_CNT - 1));

    // Asking for the next pixel while the current one is consumed keeps DataIn == mem[idx].
    assign memAddr = inc ? (idx + ADDR_W'(1)) : idx;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (inc && !isLast) begin
            idx <= idx + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/sobel_pixel_feeder.sv
// Streams one raster frame from a synchronous image RAM into the Sobel core (DataIn/Start).
// Latency: Go to Start 2 cycles, RAM read 1 cycle. Backpressure: Sobel_Pad or idle core freezes the index.
module sobel_pixel_feeder
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              Go,
    input  logic [1:0]        Sobel_State,
    input  logic              Sobel_Pad,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic [DATA_W-1:0] DataIn,
    output logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              Overrun,
    output logic [ADDR_W-1:0] Pix_Idx
);

    localparam int PIX_CNT = IMG_W * IMG_H;

    fdState_t          stateQ, stateD;
    logic              fetch, consume, isLast;
    logic [ADDR_W-1:0] idx;

    assign fetch   = coreFetching(Sobel_State, Sobel_Pad);
    assign consume = fetch && (stateQ == FD_STREAM);

    feeder_addr_ctr #(
        .ADDR_W (ADDR_W),
        .PIX_CNT(PIX_CNT)
    ) u_addrCtr (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .clear  (stateQ == FD_IDLE),
        .inc    (consume),
        .idx    (idx),
        .memAddr(Mem_Addr),
        .isLast (isLast)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            stateQ <= FD_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            FD_IDLE:   if (Go) stateD = FD_PRIME;
            FD_PRIME:  stateD = FD_ARM;
            FD_ARM:    if (Sobel_State != SOBEL_ST_IDLE) stateD = FD_STREAM;
            FD_STREAM: begin
                // A core that drops back to idle mid-frame ends a short frame.
                if (consume && isLast) begin
                    stateD = FD_DRAIN;
                end else if (Sobel_State == SOBEL_ST_IDLE) begin
                    stateD = FD_DONE;
                end
            end
            FD_DRAIN:  if (Sobel_State == SOBEL_ST_IDLE) stateD = FD_DONE;
            FD_DONE:   stateD = FD_IDLE;
            default:   stateD = FD_IDLE;
        endcase
    end

    // Sticky until the next accepted Go so software can read it after the frame.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Overrun <= 1'b0;
        end else if ((stateQ == FD_IDLE) && Go) begin
            Overrun <= 1'b0;
        end else if ((stateQ == FD_DRAIN) && fetch) begin
            Overrun <= 1'b1;
        end
    end

    always_comb begin
        DataIn = '0;
        if ((stateQ == FD_PRIME) || (stateQ == FD_ARM) || (stateQ == FD_STREAM)) begin
            DataIn = Mem_Data;
        end
    end

    assign Start   = (stateQ == FD_ARM);
    assign Busy    = (stateQ != FD_IDLE);
    assign Done    = (stateQ == FD_DONE);
    assign Pix_Idx = idx;

endmodule
